// File: rtl/emu_time_mgr_pkg.sv
// Shared emulation-timestep constants and types.
// The emulation controller imports this package too.
package emu_time_pkg;

    localparam int unsigned DT_WIDTH_DEF    = 27;
    localparam int unsigned TIME_WIDTH_DEF  = 39;
    localparam int unsigned STEP_WIDTH_DEF  = 32;
    localparam int unsigned STALL_WIDTH_DEF = 16;

    typedef logic [DT_WIDTH_DEF-1:0]   dt_t;
    typedef logic [TIME_WIDTH_DEF-1:0] time_t;

    // All-ones dt lets time run freely; zero dt halts time.
    localparam dt_t DT_FREE_RUN = '1;
    localparam dt_t DT_STOP     = '0;

endpackage

// File: rtl/emu_time_mgr_if.sv
// Timestep bus between the dt producers/controller and the time manager.
// The master side drives the requests; the slave side returns grant and time.
interface emu_time_mgr_if
    import emu_time_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DT_WIDTH   = DT_WIDTH_DEF,
    parameter int unsigned TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int unsigned STEP_WIDTH = STEP_WIDTH_DEF
);

    logic [N_REQ*DT_WIDTH-1:0] emu_dt_req;
    logic [DT_WIDTH-1:0]       emu_dt;
    logic [TIME_WIDTH-1:0]     emu_time;
    logic [STEP_WIDTH-1:0]     emu_step_cnt;
    logic                      emu_stalled;
    logic                      emu_time_sat;

    modport master (
        output emu_dt_req,
        input  emu_dt,
        input  emu_time,
        input  emu_step_cnt,
        input  emu_stalled,
        input  emu_time_sat
    );

    modport slave (
        input  emu_dt_req,
        output emu_dt,
        output emu_time,
        output emu_step_cnt,
        output emu_stalled,
        output emu_time_sat
    );

endinterface

// File: rtl/emu_time_mgr_dt_min_tree.sv
// Combinational balanced binary minimum over N_REQ packed dt requests.
// An odd leftover node at any level passes straight up to the next level.
module emu_dt_min_tree #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DT_WIDTH = 27
) (
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    output logic [DT_WIDTH-1:0]       dt_min
);

    function automatic int unsigned lvl_cnt(input int unsigned n, input int unsigned l);
        int unsigned c;
        c = n;
        for (int unsigned k = 0; k < l; k++) c = (c + 1) / 2;
        return c;
    endfunction

    function automatic int unsigned lvl_base(input int unsigned n, input int unsigned l);
        int unsigned b;
        b = 0;
        for (int unsigned k = 0; k < l; k++) b = b + lvl_cnt(n, k);
        return b;
    endfunction

    localparam int unsigned LEVELS = $clog2(N_REQ);
    localparam int unsigned N_NODE = lvl_base(N_REQ, LEVELS + 1);

    // All levels share one flat node array; level l starts at lvl_base(N_REQ, l).
    logic [DT_WIDTH-1:0] node [N_NODE];

    for (genvar i = 0; i < N_REQ; i++) begin : g_leaf
        assign node[i] = dt_req[i*DT_WIDTH +: DT_WIDTH];
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned PCNT  = lvl_cnt(N_REQ, l - 1);
        localparam int unsigned PBASE = lvl_base(N_REQ, l - 1);
        localparam int unsigned CNT   = lvl_cnt(N_REQ, l);
        localparam int unsigned BASE  = lvl_base(N_REQ, l);
        for (genvar i = 0; i < CNT; i++) begin : g_node
            if (2*i + 1 < PCNT) begin : g_pair
                assign node[BASE+i] = (node[PBASE+2*i] < node[PBASE+2*i+1])
                                    ? node[PBASE+2*i] : node[PBASE+2*i+1];
            end else begin : g_odd
                assign node[BASE+i] = node[PBASE+2*i];
            end
        end
    end

    assign dt_min = node[N_NODE-1];

endmodule

// File: rtl/emu_time_mgr.sv
// Global timestep arbiter: grants the minimum dt request and keeps the
// emulation time, executed-step and stall bookkeeping.
module emu_time_mgr
    import emu_time_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DT_WIDTH    = DT_WIDTH_DEF,
    parameter int unsigned TIME_WIDTH  = TIME_WIDTH_DEF,
    parameter int unsigned STEP_WIDTH  = STEP_WIDTH_DEF,
    parameter int unsigned STALL_WIDTH = STALL_WIDTH_DEF,
    parameter int unsigned STALL_THR   = 1024
) (
    input  logic           emu_clk,
    input  logic           emu_rst,
    emu_time_mgr_if.slave  tm
);

    localparam logic [STALL_WIDTH-1:0] STALL_LIM = STALL_WIDTH'(STALL_THR);

    logic [DT_WIDTH-1:0]    dt_min;
    logic [DT_WIDTH-1:0]    dt_grant;
    logic                   dt_nz;
    logic [TIME_WIDTH:0]    time_sum;
    logic [TIME_WIDTH-1:0]  time_q;
    logic                   time_sat_q;
    logic [STEP_WIDTH-1:0]  step_q;
    logic [STALL_WIDTH-1:0] stall_q;
    logic [STALL_WIDTH-1:0] stall_nxt;
    logic                   stalled_q;

    emu_dt_min_tree #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH)
    ) u_min_tree (
        .dt_req (tm.emu_dt_req),
        .dt_min (dt_min)
    );

    // Producers consume the grant in the same cycle, so it stays combinational.
    always_comb begin
        dt_grant = emu_rst ? '0 : dt_min;
        dt_nz    = |dt_grant;
        time_sum = {1'b0, time_q} + {{(TIME_WIDTH + 1 - DT_WIDTH){1'b0}}, dt_grant};
    end

    always_comb begin
        stall_nxt = stall_q;
        if (dt_nz) begin
            stall_nxt = '0;
        end else if (stall_q != STALL_LIM) begin
            stall_nxt = stall_q + 1'b1;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            time_q     <= '0;
            time_sat_q <= 1'b0;
            step_q     <= '0;
            stall_q    <= '0;
            stalled_q  <= 1'b0;
        end else begin
            // A carry out of the adder pins time at all-ones for good.
            if (time_sum[TIME_WIDTH]) begin
                time_q     <= '1;
                time_sat_q <= 1'b1;
            end else begin
                time_q <= time_sum[TIME_WIDTH-1:0];
            end
            if (dt_nz) begin
                step_q <= step_q + 1'b1;
            end
            stall_q   <= stall_nxt;
            stalled_q <= (stall_nxt == STALL_LIM);
        end
    end

    assign tm.emu_dt       = dt_grant;
    assign tm.emu_time     = time_q;
    assign tm.emu_step_cnt = step_q;
    assign tm.emu_stalled  = stalled_q;
    assign tm.emu_time_sat = time_sat_q;

endmodule

// File: tb/tb_emu_time_mgr.sv
// Directed bench for emu_time_mgr: min-tree vector table plus hand-written
// sequences for accumulation, stall, mid-run reset, saturation and wrap.
module tb_emu_time_mgr;
    import emu_time_pkg::*;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_cmp;
    int   n_bad;

    emu_time_mgr_if #(.N_REQ(4), .DT_WIDTH(27), .TIME_WIDTH(39), .STEP_WIDTH(32)) ifc_a ();
    emu_time_mgr_if #(.N_REQ(1), .DT_WIDTH(27), .TIME_WIDTH(39), .STEP_WIDTH(4))  ifc_b ();
    emu_time_mgr_if #(.N_REQ(5), .DT_WIDTH(27), .TIME_WIDTH(39), .STEP_WIDTH(32)) ifc_c ();

    emu_time_mgr #(.N_REQ(4), .DT_WIDTH(27), .TIME_WIDTH(39), .STEP_WIDTH(32),
                   .STALL_WIDTH(16), .STALL_THR(4)) dut_a (
        .emu_clk (clk), .emu_rst (rst_a), .tm (ifc_a.slave));
    emu_time_mgr #(.N_REQ(1), .DT_WIDTH(27), .TIME_WIDTH(39), .STEP_WIDTH(4),
                   .STALL_WIDTH(16), .STALL_THR(4)) dut_b (
        .emu_clk (clk), .emu_rst (rst_b), .tm (ifc_b.slave));
    emu_time_mgr #(.N_REQ(5), .DT_WIDTH(27), .TIME_WIDTH(39), .STEP_WIDTH(32),
                   .STALL_WIDTH(16), .STALL_THR(1024)) dut_c (
        .emu_clk (clk), .emu_rst (rst_c), .tm (ifc_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [4*27-1:0] pack4(input dt_t r0, input dt_t r1, input dt_t r2, input dt_t r3);
        return {r3, r2, r1, r0};
    endfunction

    function automatic logic [5*27-1:0] pack5(input dt_t r0, input dt_t r1, input dt_t r2,
                                              input dt_t r3, input dt_t r4);
        return {r4, r3, r2, r1, r0};
    endfunction

    typedef struct {
        logic [5*27-1:0] req;
        dt_t             exp;
    } vec_t;

    localparam dt_t   DT_MAX   = 27'h7FF_FFFF;
    localparam dt_t   DT_HALF  = 27'h400_0000;
    localparam logic [63:0] T_PRE = 64'h80_0000_0000 - 64'h400_0000;
    localparam logic [63:0] T_MAX = 64'h7F_FFFF_FFFF;

    vec_t vecs [9];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ifc_a.emu_dt_req = '0;
        ifc_b.emu_dt_req = '0;
        ifc_c.emu_dt_req = '0;

        vecs[0] = '{pack5(9, 3, 7, 5, 11),       27'd3};
        vecs[1] = '{pack5(8, 8, 8, 8, 8),        27'd8};
        vecs[2] = '{pack5(DT_MAX, DT_MAX, DT_MAX, DT_MAX, DT_MAX), DT_MAX};
        vecs[3] = '{pack5(20, 30, 40, 50, 0),    27'd0};
        vecs[4] = '{pack5(20, 30, 40, 50, 4),    27'd4};
        vecs[5] = '{pack5(1, 2, 3, 4, 5),        27'd1};
        vecs[6] = '{pack5(DT_MAX, DT_MAX, DT_MAX, DT_MAX - 27'd1, DT_MAX), DT_MAX - 27'd1};
        vecs[7] = '{pack5(DT_STOP, 100, 100, 100, 100), 27'd0};
        vecs[8] = '{pack5(6, 5, 4, 3, 2),        27'd2};

        repeat (2) @(negedge clk);

        // Reset state and grant forcing while reset is held.
        ifc_a.emu_dt_req = pack4(100, 40, 75, 40);
        #1;
        check("rst_dt_forced", 64'(ifc_a.emu_dt), 0);
        check("rst_time", 64'(ifc_a.emu_time), 0);
        check("rst_step", 64'(ifc_a.emu_step_cnt), 0);
        check("rst_stalled", 64'(ifc_a.emu_stalled), 0);
        check("rst_sat", 64'(ifc_a.emu_time_sat), 0);

        // Min tree table on the 5-input instance (odd leaf pass-through).
        @(negedge clk);
        rst_c = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ifc_c.emu_dt_req = vecs[i].req;
            #1;
            check($sformatf("min5_vec%0d", i), 64'(ifc_c.emu_dt), 64'(vecs[i].exp));
        end

        // Basic accumulation: min of {100,40,75,40} for 3 cycles.
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("acc_dt", 64'(ifc_a.emu_dt), 40);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("acc_time%0d", k), 64'(ifc_a.emu_time), 64'(40 * k));
            check($sformatf("acc_dt%0d", k), 64'(ifc_a.emu_dt), 40);
        end
        check("acc_step", 64'(ifc_a.emu_step_cnt), 3);

        // Stall: one request stops time, flag rises on the 4th zero-dt edge.
        ifc_a.emu_dt_req = pack4(5, 0, 5, 5);
        #1;
        check("stall_dt", 64'(ifc_a.emu_dt), 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_flag%0d", k), 64'(ifc_a.emu_stalled), (k >= 4) ? 64'd1 : 64'd0);
            check($sformatf("stall_time%0d", k), 64'(ifc_a.emu_time), 120);
        end
        check("stall_step", 64'(ifc_a.emu_step_cnt), 3);
        ifc_a.emu_dt_req = pack4(5, 5, 5, 5);
        #1;
        check("unstall_dt", 64'(ifc_a.emu_dt), 5);
        @(negedge clk);
        check("unstall_flag", 64'(ifc_a.emu_stalled), 0);
        check("unstall_time", 64'(ifc_a.emu_time), 125);
        check("unstall_step", 64'(ifc_a.emu_step_cnt), 4);

        // Mid-run reset from time 500 with requests at 10.
        ifc_a.emu_dt_req = pack4(375, 375, 400, 500);
        @(negedge clk);
        check("pre_rst_time", 64'(ifc_a.emu_time), 500);
        ifc_a.emu_dt_req = pack4(10, 10, 10, 10);
        rst_a = 1'b1;
        #1;
        check("midrst_dt", 64'(ifc_a.emu_dt), 0);
        @(negedge clk);
        check("midrst_time", 64'(ifc_a.emu_time), 0);
        check("midrst_step", 64'(ifc_a.emu_step_cnt), 0);
        rst_a = 1'b0;
        #1;
        check("postrst_dt", 64'(ifc_a.emu_dt), 10);
        @(negedge clk);
        check("postrst_time", 64'(ifc_a.emu_time), 10);
        check("postrst_step", 64'(ifc_a.emu_step_cnt), 1);

        // Saturation: preload to 2^39-2^26, then free-run overflows.
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        ifc_a.emu_dt_req = pack4(DT_HALF, DT_HALF, DT_MAX, DT_HALF);
        repeat (8191) @(negedge clk);
        check("pre_sat_time", 64'(ifc_a.emu_time), T_PRE);
        check("pre_sat_flag", 64'(ifc_a.emu_time_sat), 0);
        check("pre_sat_step", 64'(ifc_a.emu_step_cnt), 8191);
        ifc_a.emu_dt_req = pack4(DT_FREE_RUN, DT_FREE_RUN, DT_FREE_RUN, DT_FREE_RUN);
        #1;
        check("free_run_dt", 64'(ifc_a.emu_dt), 64'(DT_MAX));
        @(negedge clk);
        check("sat_time", 64'(ifc_a.emu_time), T_MAX);
        check("sat_flag", 64'(ifc_a.emu_time_sat), 1);
        check("sat_step", 64'(ifc_a.emu_step_cnt), 8192);
        @(negedge clk);
        check("sat_hold_time", 64'(ifc_a.emu_time), T_MAX);
        check("sat_hold_step", 64'(ifc_a.emu_step_cnt), 8193);
        ifc_a.emu_dt_req = pack4(0, 0, 0, 0);
        @(negedge clk);
        check("sat_stop_time", 64'(ifc_a.emu_time), T_MAX);
        check("sat_stop_flag", 64'(ifc_a.emu_time_sat), 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("sat_clr_flag", 64'(ifc_a.emu_time_sat), 0);
        check("sat_clr_time", 64'(ifc_a.emu_time), 0);

        // Single-request pass-through: 7, 0, 3.
        rst_b = 1'b0;
        ifc_b.emu_dt_req = 27'd7;
        #1;
        check("n1_dt7", 64'(ifc_b.emu_dt), 7);
        @(negedge clk);
        check("n1_time7", 64'(ifc_b.emu_time), 7);
        ifc_b.emu_dt_req = 27'd0;
        #1;
        check("n1_dt0", 64'(ifc_b.emu_dt), 0);
        @(negedge clk);
        check("n1_time_hold", 64'(ifc_b.emu_time), 7);
        ifc_b.emu_dt_req = 27'd3;
        #1;
        check("n1_dt3", 64'(ifc_b.emu_dt), 3);
        @(negedge clk);
        check("n1_time10", 64'(ifc_b.emu_time), 10);
        check("n1_step", 64'(ifc_b.emu_step_cnt), 2);

        // 4-bit step counter wraps after 16 unit steps.
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        ifc_b.emu_dt_req = 27'd1;
        repeat (16) @(negedge clk);
        check("wrap_step16", 64'(ifc_b.emu_step_cnt), 0);
        @(negedge clk);
        check("wrap_step17", 64'(ifc_b.emu_step_cnt), 1);
        check("wrap_time17", 64'(ifc_b.emu_time), 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/emu_time_mgr.md
Name: emu_time_mgr

Overview:
- Consumer end of the emulation timestep protocol.
- Each analog block, and the emulation controller in its run/stop/sleep-until mode, drives a dt request; this block takes the minimum as the global timestep `emu_dt`.
- It advances the global emulation time register by `emu_dt` and keeps step and stall bookkeeping for debug and the controller.
- It sits at the top of the emulator beside the controller and drives `emu_time` back to it.

Parameters:
- N_REQ, 4: number of dt request inputs; legal range is 1 or more.
- DT_WIDTH, 27: width of one dt request and of `emu_dt`.
- TIME_WIDTH, 39: width of the emulation time register; must be DT_WIDTH or more.
- STEP_WIDTH, 32: width of the executed-step counter.
- STALL_WIDTH, 16: width of the stall counter.
- STALL_THR, 1024: count of consecutive zero-dt cycles at which `emu_stalled` asserts; legal range is 1 to 2^STALL_WIDTH-1.

Ports:
- emu_clk, input, 1: emulation clock; all state updates on its rising edge.
- emu_rst, input, 1: reset, synchronous and active-high.
- emu_dt_req, input, N_REQ*DT_WIDTH: packed requests; request i occupies bits [i*DT_WIDTH +: DT_WIDTH].
- emu_dt, output, DT_WIDTH: granted timestep for the current cycle.
- emu_time, output, TIME_WIDTH: current emulation time.
- emu_step_cnt, output, STEP_WIDTH: number of cycles with nonzero `emu_dt` since reset.
- emu_stalled, output, 1: high once STALL_THR consecutive cycles have had `emu_dt` = 0.
- emu_time_sat, output, 1: sticky flag; high once `emu_time` has saturated.

Behaviour:
- `emu_dt` is combinational with zero latency, because producers apply it in the same cycle.
  - With emu_rst = 1, `emu_dt` = 0.
  - Otherwise `emu_dt` = unsigned minimum of all N_REQ requests.
  - Equal requests resolve to that common value.
  - All requests at all-ones (free-run) gives `emu_dt` = all-ones.
  - Any request at 0 (stop) gives `emu_dt` = 0.
  - N_REQ = 1 is a pass-through.
- Reset values, applied on the edge where emu_rst = 1: `emu_time` = 0, `emu_step_cnt` = 0, stall counter = 0, `emu_stalled` = 0, `emu_time_sat` = 0.
  - Reset mid-run discards all state in one cycle; no partial update occurs on that edge.
- Time update, each edge with emu_rst = 0:
  - Compute sum = `emu_time` + zero-extended `emu_dt`, at TIME_WIDTH+1 bits.
  - If the carry is set, `emu_time` <= all-ones and `emu_time_sat` <= 1.
  - Otherwise `emu_time` <= the sum.
  - Once `emu_time` is all-ones it holds there; only reset clears `emu_time_sat`.
  - Latency: `emu_time` reflects `emu_dt` one cycle after it is granted.
- Step counter: increments by 1 on every edge with `emu_dt` != 0.
  - Wraps modulo 2^STEP_WIDTH and does not saturate.
  - It still counts after time has saturated.
- Stall tracking:
  - On an edge with `emu_dt` = 0, the stall counter increments and saturates at STALL_THR.
  - On an edge with `emu_dt` != 0, the stall counter <= 0.
  - `emu_stalled` is registered and equals (stall counter == STALL_THR).
  - It therefore goes high on the STALL_THR-th consecutive zero-dt edge.
  - It clears on the first edge with nonzero dt.
- Nonzero dt after a stall, on the same edge: the counter clears, `emu_time` advances and `emu_step_cnt` increments.

Decomposition:
- Package emu_time_pkg holds:
  - width constants DT_WIDTH_DEF, TIME_WIDTH_DEF, STEP_WIDTH_DEF, STALL_WIDTH_DEF;
  - typedefs dt_t and time_t;
  - constants DT_FREE_RUN = all-ones and DT_STOP = 0, shared with the emulation controller.
- One sub-module: emu_dt_min_tree.
  - Parameterised on N_REQ and DT_WIDTH.
  - Combinational balanced binary minimum tree with a pass-through for odd leaves.
  - Its output is unregistered.
- emu_time_mgr holds all registers and the reset forcing of `emu_dt`.

Test Plan:
- Reset, then requests {100, 40, 75, 40}, held for 3 cycles: `emu_dt` = 40 each cycle; `emu_time` goes 40, 80, 120; `emu_step_cnt` = 3.
- All requests 2^27-1, TIME_WIDTH = 39, emu_time preloaded by running to 2^39-2^26: on the next edge `emu_time` = 2^39-1 and `emu_time_sat` = 1; it stays there on later edges while `emu_step_cnt` keeps incrementing.
- One request = 0, others = 5, STALL_THR = 4: `emu_stalled` = 0 after 3 edges and 1 after the 4th edge; `emu_time` is unchanged. Releasing to 5 gives `emu_stalled` = 0 and `emu_time` += 5 on the next edge.
- emu_rst pulsed for 1 cycle mid-run with `emu_time` = 500 and requests = 10: `emu_dt` = 0 during reset; `emu_time` = 0 after the reset edge, then 10 on the following edge.
- STEP_WIDTH = 4, dt = 1 for 17 cycles: `emu_step_cnt` wraps to 1 and `emu_time` = 17.
- N_REQ = 1, request sequence 7, 0, 3: `emu_dt` follows the request exactly; `emu_time` goes 7, 7, 10; `emu_step_cnt` = 2.
